dtfag_idx_seq: RTL

- Issue-side sequencer for the DTFAG twiddle path of the radix-16, 65536-point FFT.
- Walks all butterfly groups of every stage and drives DTFAG_i/DTFAG_t/DTFAG_j plus ROM_CEN into DTFAG_top.
- Keeps a tag pipeline matched to the AGU+ROM read latency, so the butterfly datapath knows when the ROM outputs are valid and which stage/group they belong to.

---
 rtl/dtfag_idx_seq.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/dtfag_idx_seq.sv
// dtfag_idx_seq: issue-side sequencer for the DTFAG twiddle path of the
// radix-16, 65536-point FFT. It walks every butterfly group of every stage and
// drives the DTFAG_top index digits and ROM read enable. A tag pipeline, matched
// to the AGU+ROM read latency, tells the butterfly datapath when the twiddle
// outputs are valid and which stage/group they belong to.
//
// Optional feature: define DTFAG_SEQ_PERF_EN to add the 32-bit stall_cnt output
// (stall cycles seen in RUN, saturating, cleared when a run is accepted).
// RADIX_W is expected to match the project-wide radix width used by DTFAG_top.
module dtfag_idx_seq #(
  parameter int RADIX_W   = 4,
  parameter int NUM_STAGE = 4,
  parameter int GRP_W     = 12,
  parameter int RD_LAT    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stall,
  output logic               busy,
  output logic               done,
  output logic [RADIX_W-1:0] DTFAG_i,
  output logic [RADIX_W-1:0] DTFAG_t,
  output logic [RADIX_W-1:0] DTFAG_j,
  output logic               ROM_CEN,
  output logic               tf_valid,
  output logic [1:0]         tf_stage,
  output logic [GRP_W-1:0]   tf_grp
`ifdef DTFAG_SEQ_PERF_EN
  ,
  output logic [31:0]        stall_cnt
`endif
);

  localparam logic [1:0] LAST_STAGE = 2'(NUM_STAGE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [1:0]       r_stage;
  logic [GRP_W-1:0] r_grp;
  logic [GRP_W-1:0] w_k;
  logic             w_issue;
  logic             w_lastIssue;
  logic             w_startAccept;
  logic             w_pending;

  // Tag travelling alongside ROM_CEN; it becomes the head of the latency pipe.
  logic             r_issueVld;
  logic [1:0]       r_issueStage;
  logic [GRP_W-1:0] r_issueGrp;

  // Latency-matching tag pipe; the last slot is what the datapath sees.
  logic [RD_LAT-1:0] r_pipeVld;
  logic [1:0]        r_pipeStage [RD_LAT];
  logic [GRP_W-1:0]  r_pipeGrp   [RD_LAT];

  assign w_startAccept = (r_state == S_IDLE) && start;
  assign w_issue       = (r_state == S_RUN) && !stall;
  assign w_lastIssue   = w_issue && (r_stage == LAST_STAGE) && (r_grp == '1);

  // Twiddle index: group counter shifted left by one digit per stage; the
  // bits shifted past the top are dropped, so the last stage always reads k=0.
  assign w_k = r_grp << (RADIX_W * r_stage);

  // A read is still in flight if any slot before the output slot holds one.
  always_comb begin
    w_pending = r_issueVld;
    for (int n = 0; n < RD_LAT - 1; n++) begin
      w_pending = w_pending | r_pipeVld[n];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: the run ends once the final read has left the pipe.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (start) w_nextState = S_RUN;
      S_RUN:   if (w_lastIssue) w_nextState = S_DRAIN;
      S_DRAIN: if (!w_pending) w_nextState = S_DONE;
      S_DONE:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // FSM outputs: busy covers issue and drain, done is the single DONE cycle.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_RUN, S_DRAIN: busy = 1'b1;
      S_DONE:         done = 1'b1;
      default:        ;
    endcase
  end

  // Stage/group walk: restarted on acceptance, advanced only on an issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stage <= '0;
      r_grp   <= '0;
    end else if (w_startAccept) begin
      r_stage <= '0;
      r_grp   <= '0;
    end else if (w_issue) begin
      r_grp <= r_grp + 1'b1;
      if (r_grp == '1) begin
        r_stage <= r_stage + 1'b1;
      end
    end
  end

  // Registered ROM interface: indices update only on issue, so they hold on stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      DTFAG_i      <= '0;
      DTFAG_t      <= '0;
      DTFAG_j      <= '0;
      ROM_CEN      <= 1'b1;
      r_issueVld   <= 1'b0;
      r_issueStage <= '0;
      r_issueGrp   <= '0;
    end else begin
      ROM_CEN    <= !w_issue;
      r_issueVld <= w_issue;
      if (w_issue) begin
        DTFAG_i      <= w_k[3*RADIX_W-1:2*RADIX_W];
        DTFAG_t      <= w_k[2*RADIX_W-1:RADIX_W];
        DTFAG_j      <= w_k[RADIX_W-1:0];
        r_issueStage <= r_stage;
        r_issueGrp   <= r_grp;
      end
    end
  end

  // Tag pipe shifts every cycle; stall never holds it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pipeVld <= '0;
      for (int n = 0; n < RD_LAT; n++) begin
        r_pipeStage[n] <= '0;
        r_pipeGrp[n]   <= '0;
      end
    end else begin
      r_pipeVld[0]   <= r_issueVld;
      r_pipeStage[0] <= r_issueStage;
      r_pipeGrp[0]   <= r_issueGrp;
      for (int n = 1; n < RD_LAT; n++) begin
        r_pipeVld[n]   <= r_pipeVld[n-1];
        r_pipeStage[n] <= r_pipeStage[n-1];
        r_pipeGrp[n]   <= r_pipeGrp[n-1];
      end
    end
  end

  assign tf_valid = r_pipeVld[RD_LAT-1];
  assign tf_stage = r_pipeStage[RD_LAT-1];
  assign tf_grp   = r_pipeGrp[RD_LAT-1];

`ifdef DTFAG_SEQ_PERF_EN
  // Saturating count of RUN cycles lost to backpressure; kept after done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (w_startAccept) begin
      stall_cnt <= '0;
    end else if ((r_state == S_RUN) && stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule
